// File: rtl/frame_uart_tx.sv
// Frame-to-UART bridge: buffers 40-bit frames and sends each as 5 bytes, 8N1, MSB byte first.
// Define FRAME_DELIM_EN to append a CR/LF (0x0D, 0x0A) pair after every frame.
module frame_uart_tx #(
    parameter int unsigned CLK_FREQ   = 500_000,
    parameter int unsigned BAUD       = 9600,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [39:0]                   para_in,
    input  logic                          para_valid,
    input  logic                          clr_ovf,
    output logic                          uart_tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);
    localparam int unsigned ClksPerBit = CLK_FREQ / BAUD;
    localparam int unsigned CntW       = $clog2(ClksPerBit);
    localparam int unsigned PtrW       = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW       = PtrW + 1;
    localparam logic [CntW-1:0] BaudMax = CntW'(ClksPerBit - 1);
`ifdef FRAME_DELIM_EN
    localparam logic [2:0] LastByte = 3'd6;
`else
    localparam logic [2:0] LastByte = 3'd4;
`endif

    typedef enum logic [2:0] {StIdle, StLoad, StStart, StData, StStop} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [2:0]        byte_q, byte_d;
    logic [39:0]       frame_q, frame_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]   level_q, level_d;
    logic              ovf_q, ovf_d;
    logic              tx_q, tx_d;
    logic [39:0]       mem [FIFO_DEPTH];
    logic              push, pop, baud_done;
    logic [7:0]        cur_byte;

    // A pop in the LOAD cycle frees a slot, so a push into a full FIFO is accepted then.
    always_comb begin
        pop      = (state_q == StLoad);
        push     = para_valid && ((level_q != LvlW'(FIFO_DEPTH)) || pop);
        wr_ptr_d = wr_ptr_q + PtrW'(push);
        rd_ptr_d = rd_ptr_q + PtrW'(pop);
        level_d  = level_q + LvlW'(push) - LvlW'(pop);
        if (para_valid && !push) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q + CntW'(1);
        bit_d     = bit_q;
        byte_d    = byte_q;
        frame_d   = frame_q;
        baud_done = (baud_q == BaudMax);
        case (state_q)
            StIdle: begin
                baud_d = '0;
                if (level_q != '0) state_d = StLoad;
            end
            StLoad: begin
                frame_d = mem[rd_ptr_q];
                byte_d  = '0;
                bit_d   = '0;
                baud_d  = '0;
                state_d = StStart;
            end
            StStart: begin
                if (baud_done) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = StData;
                end
            end
            StData: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) state_d = StStop;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            StStop: begin
                if (baud_done) begin
                    baud_d = '0;
                    if (byte_q != LastByte) begin
                        byte_d  = byte_q + 3'd1;
                        state_d = StStart;
                    end else if (level_q != '0) begin
                        state_d = StLoad;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Line level is registered from the next state so uart_tx is glitch-free.
    always_comb begin
        case (byte_d)
            3'd0:    cur_byte = frame_d[39:32];
            3'd1:    cur_byte = frame_d[31:24];
            3'd2:    cur_byte = frame_d[23:16];
            3'd3:    cur_byte = frame_d[15:8];
            3'd4:    cur_byte = frame_d[7:0];
`ifdef FRAME_DELIM_EN
            3'd5:    cur_byte = 8'h0D;
            3'd6:    cur_byte = 8'h0A;
`endif
            default: cur_byte = 8'hFF;
        endcase
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = cur_byte[bit_d];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            baud_q   <= '0;
            bit_q    <= '0;
            byte_q   <= '0;
            frame_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            frame_q  <= frame_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
            tx_q     <= tx_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= para_in;
    end

    assign uart_tx    = tx_q;
    assign busy       = (state_q != StIdle) || (level_q != '0);
    assign fifo_level = level_q;
    assign overflow   = ovf_q;
endmodule

// File: tb/tb_frame_uart_tx.sv
// Bench for frame_uart_tx: a UART line decoder collects bytes, compared against a byte-level
// model of the frames the bench expects to be accepted.
module tb_frame_uart_tx;
    localparam int CPB = 10;
`ifdef FRAME_DELIM_EN
    localparam int NB = 7;
`else
    localparam int NB = 5;
`endif
    localparam int ByteCyc  = 10 * CPB;
    localparam int FrameCyc = NB * ByteCyc;

    logic        clk = 1'b0;
    logic        rst, para_valid, clr_ovf;
    logic [39:0] para_in;
    logic        uart_tx, busy, overflow;
    logic [2:0]  fifo_level;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    logic [8:0] rx_q[$];
    int         rx_t[$];
    logic [7:0] exp_q[$];
    bit         rx_active = 1'b0;
    int         rx_start = 0;
    logic [7:0] rx_sh = '0;

    frame_uart_tx #(.CLK_FREQ(100), .BAUD(10), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .para_in(para_in), .para_valid(para_valid), .clr_ovf(clr_ovf),
        .uart_tx(uart_tx), .busy(busy), .fifo_level(fifo_level), .overflow(overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Line decoder: samples each bit mid-cell; stores {stop_bit, data}.
    always @(negedge clk) begin
        if (rst) begin
            rx_active <= 1'b0;
        end else if (!rx_active) begin
            if (uart_tx === 1'b0) begin
                rx_active <= 1'b1;
                rx_start  <= cyc;
            end
        end else if ((cyc - rx_start) % CPB == CPB / 2) begin
            if ((cyc - rx_start) / CPB == 9) begin
                rx_q.push_back({uart_tx, rx_sh});
                rx_t.push_back(rx_start);
                rx_active <= 1'b0;
            end else if ((cyc - rx_start) / CPB >= 1) begin
                rx_sh[(cyc - rx_start) / CPB - 1] <= uart_tx;
            end
        end
    end

    function automatic void model_frame(input logic [39:0] f);
        for (int b = 0; b < 5; b++) exp_q.push_back(f[39 - 8 * b -: 8]);
`ifdef FRAME_DELIM_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endfunction

    function automatic logic [39:0] rand_frame();
        return {8'($urandom), 32'($urandom)};
    endfunction

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; para_valid = 1'b0; clr_ovf = 1'b0; para_in = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rx_q.delete(); rx_t.delete(); exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; para_valid = 1'b1; clr_ovf = 1'b0; para_in = rand_frame();
        repeat (3) @(negedge clk);
        n_chk++; if (uart_tx !== 1'b1) $display("FAIL reset_tx: got %b want 1", uart_tx); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_chk++; if (fifo_level !== 3'd0) $display("FAIL reset_level: got %0d want 0", fifo_level); else n_pass++;
        n_chk++; if (overflow !== 1'b0) $display("FAIL reset_ovf: got %b want 0", overflow); else n_pass++;
        para_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_single();
        int s;
        do_reset();
        s = cyc;
        para_in = 40'hCC12345678; para_valid = 1'b1; model_frame(40'hCC12345678);
        @(negedge clk);
        para_valid = 1'b0;
        n_chk++; if (fifo_level !== 3'd1) $display("FAIL single_level: got %0d want 1", fifo_level); else n_pass++;
        wait_cyc(s + 2);
        n_chk++; if (uart_tx !== 1'b1) $display("FAIL single_pre_start: got %b want 1", uart_tx); else n_pass++;
        wait_cyc(s + 3);
        n_chk++; if (uart_tx !== 1'b0) $display("FAIL single_start_edge: got %b want 0", uart_tx); else n_pass++;
        wait_cyc(s + 2 + FrameCyc);
        n_chk++; if (busy !== 1'b1) $display("FAIL single_busy_last_stop: got %b want 1", busy); else n_pass++;
        wait_cyc(s + 3 + FrameCyc);
        n_chk++; if (busy !== 1'b0) $display("FAIL single_busy_fall: got %b want 0", busy); else n_pass++;
        n_chk++; if (rx_q.size() != exp_q.size()) $display("FAIL single_count: got %0d want %0d", rx_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_chk++; if (rx_q[i] !== {1'b1, exp_q[i]}) $display("FAIL single_byte%0d: got %h want %h", i, rx_q[i], {1'b1, exp_q[i]}); else n_pass++;
        end
        if (rx_t.size() == NB) begin
            n_chk++; if (rx_t[4] != s + 3 + 4 * ByteCyc) $display("FAIL single_byte4_time: got %0d want %0d", rx_t[4], s + 3 + 4 * ByteCyc); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int s, mx;
        int exp_lvl[4];
        exp_lvl = '{1, 2, 2, 3};
        do_reset();
        s = cyc;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                n_chk++; if (fifo_level !== 3'(exp_lvl[i-1])) $display("FAIL b2b_level_c%0d: got %0d want %0d", i, fifo_level, exp_lvl[i-1]); else n_pass++;
            end
            para_in = rand_frame(); para_valid = 1'b1; model_frame(para_in);
            @(negedge clk);
        end
        para_valid = 1'b0;
        mx = 0;
        for (int i = 0; i < 10; i++) begin
            if (fifo_level > mx) mx = fifo_level;
            @(negedge clk);
        end
        n_chk++; if (mx != 3) $display("FAIL b2b_peak_level: got %0d want 3", mx); else n_pass++;
        wait_cyc(s + 3 + 4 * (FrameCyc + 1) + 2);
        n_chk++; if (busy !== 1'b0) $display("FAIL b2b_busy_end: got %b want 0", busy); else n_pass++;
        n_chk++; if (overflow !== 1'b0) $display("FAIL b2b_ovf: got %b want 0", overflow); else n_pass++;
        n_chk++; if (rx_q.size() != exp_q.size()) $display("FAIL b2b_count: got %0d want %0d", rx_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_chk++; if (rx_q[i] !== {1'b1, exp_q[i]}) $display("FAIL b2b_byte%0d: got %h want %h", i, rx_q[i], {1'b1, exp_q[i]}); else n_pass++;
        end
        for (int f = 1; f < 4 && f * NB < rx_t.size(); f++) begin
            n_chk++; if (rx_t[f*NB] != s + 3 + f * (FrameCyc + 1)) $display("FAIL b2b_frame%0d_time: got %0d want %0d", f, rx_t[f*NB], s + 3 + f * (FrameCyc + 1)); else n_pass++;
        end
    endtask

    task automatic test_overflow();
        int s;
        do_reset();
        s = cyc;
        for (int i = 0; i < 6; i++) begin
            para_in = rand_frame(); para_valid = 1'b1;
            if (i < 5) model_frame(para_in);
            @(negedge clk);
        end
        n_chk++; if (overflow !== 1'b1) $display("FAIL ovf_set: got %b want 1", overflow); else n_pass++;
        n_chk++; if (fifo_level !== 3'd4) $display("FAIL ovf_level_full: got %0d want 4", fifo_level); else n_pass++;
        para_in = rand_frame(); clr_ovf = 1'b1;
        @(negedge clk);
        n_chk++; if (overflow !== 1'b1) $display("FAIL ovf_set_wins: got %b want 1", overflow); else n_pass++;
        para_valid = 1'b0;
        @(negedge clk);
        clr_ovf = 1'b0;
        n_chk++; if (overflow !== 1'b0) $display("FAIL ovf_clear: got %b want 0", overflow); else n_pass++;
        wait_cyc(s + 3 + 5 * (FrameCyc + 1) + 2);
        n_chk++; if (overflow !== 1'b0) $display("FAIL ovf_stays_clear: got %b want 0", overflow); else n_pass++;
        n_chk++; if (rx_q.size() != exp_q.size()) $display("FAIL ovf_count: got %0d want %0d", rx_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_chk++; if (rx_q[i] !== {1'b1, exp_q[i]}) $display("FAIL ovf_byte%0d: got %h want %h", i, rx_q[i], {1'b1, exp_q[i]}); else n_pass++;
        end
    endtask

    task automatic test_full_pop();
        int s, ld;
        do_reset();
        s = cyc;
        for (int i = 0; i < 5; i++) begin
            para_in = rand_frame(); para_valid = 1'b1; model_frame(para_in);
            @(negedge clk);
        end
        para_valid = 1'b0;
        ld = s + 3 + FrameCyc;
        wait_cyc(ld);
        n_chk++; if (fifo_level !== 3'd4) $display("FAIL fullpop_level_before: got %0d want 4", fifo_level); else n_pass++;
        n_chk++; if (uart_tx !== 1'b1) $display("FAIL fullpop_line_high: got %b want 1", uart_tx); else n_pass++;
        para_in = rand_frame(); para_valid = 1'b1; model_frame(para_in);
        @(negedge clk);
        para_valid = 1'b0;
        n_chk++; if (fifo_level !== 3'd4) $display("FAIL fullpop_level_after: got %0d want 4", fifo_level); else n_pass++;
        n_chk++; if (overflow !== 1'b0) $display("FAIL fullpop_ovf: got %b want 0", overflow); else n_pass++;
        n_chk++; if (uart_tx !== 1'b0) $display("FAIL fullpop_next_start: got %b want 0", uart_tx); else n_pass++;
        wait_cyc(s + 3 + 6 * (FrameCyc + 1) + 2);
        n_chk++; if (rx_q.size() != exp_q.size()) $display("FAIL fullpop_count: got %0d want %0d", rx_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_chk++; if (rx_q[i] !== {1'b1, exp_q[i]}) $display("FAIL fullpop_byte%0d: got %h want %h", i, rx_q[i], {1'b1, exp_q[i]}); else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        int s, r;
        logic [39:0] f;
        do_reset();
        s = cyc;
        f = rand_frame();
        para_in = f; para_valid = 1'b1;
        exp_q.push_back(f[39:32]); exp_q.push_back(f[31:24]);
        @(negedge clk);
        para_in = rand_frame();
        @(negedge clk);
        para_valid = 1'b0;
        r = s + 3 + 2 * ByteCyc + 4 * CPB + 5;
        wait_cyc(r);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_chk++; if (uart_tx !== 1'b1) $display("FAIL rstmid_tx: got %b want 1", uart_tx); else n_pass++;
        n_chk++; if (fifo_level !== 3'd0) $display("FAIL rstmid_level: got %0d want 0", fifo_level); else n_pass++;
        n_chk++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else n_pass++;
        wait_cyc(r + 2 * FrameCyc);
        n_chk++; if (rx_q.size() != exp_q.size()) $display("FAIL rstmid_count: got %0d want %0d", rx_q.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
            n_chk++; if (rx_q[i] !== {1'b1, exp_q[i]}) $display("FAIL rstmid_byte%0d: got %h want %h", i, rx_q[i], {1'b1, exp_q[i]}); else n_pass++;
        end
    endtask

    initial begin
        rst = 1'b1; para_valid = 1'b0; clr_ovf = 1'b0; para_in = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/frame_uart_tx.md
Name: frame_uart_tx

Overview:
- Downstream of the QPSK demodulator; consumes the 40-bit parallel frames the demodulator produces.
- Buffers accepted frames in a small FIFO.
- Serialises each frame as 5 UART bytes (8N1) to a host for logging/inspection.
- Runs on the same clock as the demodulator's output stage.

Parameters:
- CLK_FREQ, 500_000, input clock frequency in Hz (sample clock).
- BAUD, 9600, UART bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD (integer division, must be ≥ 4).
- FIFO_DEPTH, 4, number of 40-bit frames buffered; power of 2, ≥ 2.

Ports:
- clk  in  1  block clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- para_in  in  40  demodulated frame; bits [39:32] = header, [31:8] = payload, [7:0] = checksum.
- para_valid  in  1  one-cycle strobe; para_in is valid in the same cycle.
- uart_tx  out  1  UART serial line, idle high.
- busy  out  1  high while any byte is being transmitted or the FIFO is non-empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of frames currently stored.
- overflow  out  1  sticky; set when a para_valid is dropped because the FIFO is full.
- clr_ovf  in  1  synchronous clear of overflow.

Behaviour:
- Reset values: uart_tx=1, busy=0, fifo_level=0, overflow=0. FIFO pointers are 0, FSM is IDLE, bit and baud counters are 0.
- Reset asserted mid-byte: uart_tx returns high on the next edge. The partial frame and all buffered frames are discarded.
- FIFO write:
  - para_valid with fifo_level<FIFO_DEPTH stores para_in at wr_ptr; fifo_level increments.
  - para_valid with the FIFO full drops the word and sets overflow.
  - Full plus a simultaneous pop: the push is accepted, because the pop frees the slot in the same cycle; fifo_level is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- clr_ovf clears overflow. If clr_ovf coincides with a new drop event, set wins.
- FSM states: IDLE, LOAD, START, DATA, STOP.
  - IDLE: if fifo_level>0, go to LOAD.
  - LOAD (1 cycle): pop the head frame into a 40-bit shift register; byte_idx=0.
  - START: uart_tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits of the current byte, LSB first, each CLKS_PER_BIT cycles.
  - STOP: uart_tx=1 for CLKS_PER_BIT cycles. Then, if byte_idx<4, increment byte_idx and go to START. Otherwise go to IDLE (or to LOAD directly if the FIFO is non-empty).
  - Byte order is MSB byte first: para_in[39:32], [31:24], [23:16], [15:8], [7:0].
- Latency: from a para_valid into an empty FIFO with the FSM in IDLE, the start bit begins driving uart_tx 3 cycles later (write, IDLE→LOAD, LOAD→START).
- Frame time: 5×10×CLKS_PER_BIT cycles. Back-to-back frames have no extra idle gap beyond the LOAD cycle; the line stays high during that cycle.
- The baud counter counts 0..CLKS_PER_BIT-1 and resets at every state entry.
- busy = (state!=IDLE) || (fifo_level!=0).
- fifo_level decrements on the LOAD cycle.

Optional Feature:
- Macro: FRAME_DELIM_EN.
- Defined: after the 5th byte's STOP, two extra bytes 0x0D and 0x0A are sent (same 8N1 timing) before returning to IDLE/LOAD. Frame time becomes 7×10×CLKS_PER_BIT cycles.
- Undefined: exactly 5 bytes per frame; no delimiter logic is synthesised.

Test Plan:
- Single frame: CLK_FREQ=100, BAUD=10 (10 clks/bit); pulse para_valid with 40'hCC12345678.
  - Expect bytes CC,12,34,56,78 on uart_tx, LSB first, with start and stop bits; start edge 3 cycles after the strobe.
  - busy falls 1 cycle after the last stop bit ends.
- Back-to-back: 4 strobes on consecutive cycles (FIFO_DEPTH=4), values CC000001..CC000004.
  - fifo_level peaks at 3, since the first frame pops on LOAD.
  - All 20 bytes are sent in order; overflow stays 0.
- Overflow: 6 strobes on consecutive cycles.
  - Exactly 5 frames are transmitted: 1 in flight plus 4 buffered.
  - The 6th is dropped; overflow=1. Pulse clr_ovf → overflow=0.
- Full plus simultaneous pop: fill the FIFO while the FSM is transmitting; assert para_valid on the LOAD cycle.
  - The word is accepted; fifo_level stays 4.
- Reset mid-byte: assert rst during the DATA bit 3 of byte 2.
  - uart_tx=1 next cycle; fifo_level=0; no further bytes are sent.
- FRAME_DELIM_EN defined: single frame CC12345678 → bytes CC,12,34,56,78,0D,0A.
